// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions for the fetch stage
// Purpose: widths, NOP encoding, fetch FSM state type and PC alignment mask.
// Ports: none (package).
package cpu_defs;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [INST_W-1:0] NOP_INST      = 32'h0000_0000;
  localparam logic [PC_W-1:0]   PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_RUN  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction ROM bus between fetch stage and ROM
// Purpose: groups ROM enable, word address and returned instruction.
// Signals: rom_ce_o (enable), rom_addr_o[ADDR_W] (word address),
//          rom_inst_i[32] (combinational instruction from the ROM).
// Modports: master = fetch stage side, slave = ROM side.
interface if_stage_if #(
  parameter int ADDR_W = 6
);

  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [31:0]       rom_inst_i;

  modport master (
    output rom_ce_o,
    output rom_addr_o,
    input  rom_inst_i
  );

  modport slave (
    input  rom_ce_o,
    input  rom_addr_o,
    output rom_inst_i
  );

endinterface

// File: rtl/if_stage_pc_gen.sv
// rtl/if_stage_pc_gen.sv - fetch FSM, program counter and next-PC priority mux
// Purpose: owns the IDLE/RUN state, the PC register and ROM enable/address.
// Ports: clk, rst (async, active-high); stall_i, branch_flag_i,
//        branch_target_i, flush_i, new_pc_i (redirect controls);
//        pc_o (current fetch PC); rom_ce_o, rom_addr_o (ROM request);
//        load_o (IF/ID captures a real instruction this edge);
//        bubble_o (IF/ID is cleared this edge).
module if_pc_gen
  import cpu_defs::*;
#(
  parameter int              ADDR_W   = 6,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [PC_W-1:0]   branch_target_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   new_pc_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              load_o,
  output logic              bubble_o
);

  if_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Priority in RUN: flush > stall > branch > sequential.
  // IDLE only spends one edge so RESET_PC becomes the first fetched address.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    load_o   = 1'b0;
    bubble_o = 1'b0;
    case (state_q)
      IF_IDLE: begin
        state_d = IF_RUN;
      end
      IF_RUN: begin
        if (flush_i) begin
          pc_d     = new_pc_i & PC_ALIGN_MASK;
          bubble_o = 1'b1;
        end else if (stall_i) begin
          // Branch is held by ID until the stall releases.
          pc_d = pc_q;
        end else if (branch_flag_i) begin
          pc_d   = branch_target_i & PC_ALIGN_MASK;
          load_o = 1'b1;
        end else begin
          pc_d   = pc_q + 32'd4;
          load_o = 1'b1;
        end
      end
      default: begin
        state_d = IF_IDLE;
      end
    endcase
  end

  assign pc_o       = pc_q;
  assign rom_ce_o   = (state_q == IF_RUN);
  assign rom_addr_o = pc_q[ADDR_W+1:2];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
// Purpose: drives the instruction ROM and captures its output into IF/ID.
// Optional macro IF_PERF_CNT_EN adds fetch_cnt_o, a saturating count of
// edges that load a real instruction into IF/ID.
// Ports: clk, rst (async, active-high); stall_i; branch_flag_i,
//        branch_target_i; flush_i, new_pc_i; rom (ROM bus, master);
//        pc_o; id_pc_o, id_inst_o (IF/ID register); fetch_cnt_o (optional).
module if_stage
  import cpu_defs::*;
#(
  parameter int              ADDR_W   = 6,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [PC_W-1:0]   branch_target_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   new_pc_i,
  if_stage_if.master        rom,
  output logic [PC_W-1:0]   pc_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       fetch_cnt_o,
`endif
  output logic [PC_W-1:0]   id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  logic              load;
  logic              bubble;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [PC_W-1:0]   id_pc_q;
  logic [INST_W-1:0] id_inst_q;

  if_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .pc_o            (pc_o),
    .rom_ce_o        (rom_ce),
    .rom_addr_o      (rom_addr),
    .load_o          (load),
    .bubble_o        (bubble)
  );

  assign rom.rom_ce_o   = rom_ce;
  assign rom.rom_addr_o = rom_addr;

  // Branches keep the delay slot: the instruction at the current PC is
  // captured exactly as in the sequential case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
    end else if (bubble) begin
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
    end else if (load) begin
      id_pc_q   <= pc_o;
      id_inst_q <= rom.rom_inst_i;
    end
  end

  assign id_pc_o   = id_pc_q;
  assign id_inst_o = id_inst_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
    end else if (load && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule
